// File: rtl/step_pulse_gen_if.sv
// Command/status bundle between the motion controller and the step pulse stage.
// The controller side is the master; the pulse generator is the slave.
interface step_pulse_gen_if;
  logic [5:0] MotorOut;
  logic [9:0] PulseNum;
  logic [5:0] DROut;
  logic       Busy;
  logic [5:0] PUL;
  logic [5:0] DIR;
  logic       Done;
  logic [9:0] Remain;

  modport master (
    output MotorOut, PulseNum, DROut,
    input  Busy, PUL, DIR, Done, Remain
  );

  modport slave (
    input  MotorOut, PulseNum, DROut,
    output Busy, PUL, DIR, Done, Remain
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Step/direction pulse stage for six stepper drivers: DIR setup, N STEP pulses, Done strobe.
// Define SOFTSTART_EN to stretch the LOW phase to 4*LOW_CYC on the first and last RAMP_N steps.
module step_pulse_gen #(
  parameter int HIGH_CYC  = 50,
  parameter int LOW_CYC   = 50,
  parameter int DIR_SETUP = 10,
  parameter int RAMP_N    = 8
) (
  input logic             sysclk,
  input logic             INIT,
  step_pulse_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  localparam logic [15:0] SETUP_LOAD = 16'(DIR_SETUP - 1);
  localparam logic [15:0] HIGH_LOAD  = 16'(HIGH_CYC - 1);
  localparam logic [15:0] LOW_LOAD   = 16'(LOW_CYC - 1);

  // Zero-length phases cannot be timed by a reload-to-(len-1) counter.
  if (HIGH_CYC < 1 || LOW_CYC < 1 || DIR_SETUP < 1 || RAMP_N < 0) begin : g_bad_params
    $error("step_pulse_gen: HIGH_CYC, LOW_CYC and DIR_SETUP must be >= 1");
  end

  state_t      state;
  logic [15:0] timer;
  logic [5:0]  sel;
  logic [5:0]  pul;
  logic [5:0]  dir;
  logic [9:0]  remain;
  logic        busy;
  logic        done;
  logic [21:0] last_tuple;
  logic [21:0] tuple;
  logic        one_hot;
  logic        accept;
  logic [15:0] low_load;

  assign tuple   = {bus.MotorOut, bus.PulseNum, bus.DROut};
  assign one_hot = (bus.MotorOut != 6'd0) &&
                   ((bus.MotorOut & (bus.MotorOut - 6'd1)) == 6'd0);
  assign accept  = one_hot && (bus.PulseNum != 10'd0) && (tuple != last_tuple);

`ifdef SOFTSTART_EN
  localparam logic [15:0] SLOW_LOAD = 16'(4 * LOW_CYC - 1);
  localparam logic [9:0]  RAMP      = 10'(RAMP_N);

  logic [9:0] n_total;
  logic [9:0] step_idx;

  // remain was already decremented on HIGH entry, so this is the 1-based step just issued.
  assign step_idx = n_total - remain;
  assign low_load = ((step_idx <= RAMP) || (remain < RAMP)) ? SLOW_LOAD : LOW_LOAD;
`else
  assign low_load = LOW_LOAD;
`endif

  always_ff @(posedge sysclk or posedge INIT) begin
    if (INIT) begin
      state      <= IDLE;
      timer      <= 16'd0;
      sel        <= 6'd0;
      pul        <= 6'd0;
      dir        <= 6'd0;
      remain     <= 10'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      last_tuple <= 22'd0;
`ifdef SOFTSTART_EN
      n_total    <= 10'd0;
`endif
    end else begin
      timer <= (timer == 16'd0) ? 16'd0 : timer - 16'd1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sel        <= bus.MotorOut;
            dir        <= (dir & ~bus.MotorOut) | (bus.DROut & bus.MotorOut);
            remain     <= bus.PulseNum;
            last_tuple <= tuple;
            busy       <= 1'b1;
            timer      <= SETUP_LOAD;
            state      <= SETUP;
`ifdef SOFTSTART_EN
            n_total    <= bus.PulseNum;
`endif
          end
        end
        SETUP: begin
          if (timer == 16'd0) begin
            pul    <= sel;
            remain <= remain - 10'd1;
            timer  <= HIGH_LOAD;
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (timer == 16'd0) begin
            pul   <= 6'd0;
            timer <= low_load;
            state <= LOW;
          end
        end
        LOW: begin
          if (timer == 16'd0) begin
            if (remain != 10'd0) begin
              pul    <= sel;
              remain <= remain - 10'd1;
              timer  <= HIGH_LOAD;
              state  <= HIGH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.PUL    = pul;
  assign bus.DIR    = dir;
  assign bus.Done   = done;
  assign bus.Remain = remain;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: timeline model compared every cycle plus literal checks.
// Build with +define+SOFTSTART_EN to exercise the soft-start ramp expectations.
module tb_step_pulse_gen;

  localparam int HIGH_CYC  = 50;
  localparam int LOW_CYC   = 50;
  localparam int DIR_SETUP = 10;
  localparam int RAMP_N    = 8;
`ifdef SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic INIT   = 1'b0;

  step_pulse_gen_if bus ();

  step_pulse_gen #(
    .HIGH_CYC (HIGH_CYC),
    .LOW_CYC  (LOW_CYC),
    .DIR_SETUP(DIR_SETUP),
    .RAMP_N   (RAMP_N)
  ) dut (
    .sysclk(sysclk),
    .INIT  (INIT),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s wait bound expired at %0t", name, $time);
  endtask

  // Model: a move is a timeline of phases measured from the accept edge.
  function automatic int low_width(input int k, input int n);
    int w;
    w = (RAMP_N < n) ? RAMP_N : n;
    return (SOFT && (k <= w || k > n - w)) ? 4 * LOW_CYC : LOW_CYC;
  endfunction

  function automatic int move_len(input int n);
    int total;
    total = DIR_SETUP + 1;
    for (int k = 1; k <= n; k++) total += HIGH_CYC + low_width(k, n);
    return total;
  endfunction

  task automatic expect_at(input int e, input int n, output logic busy, output logic pul_on,
                           output logic done, output int remain);
    int pos;
    int lw;
    busy   = 1'b1;
    pul_on = 1'b0;
    done   = 1'b0;
    remain = n;
    if (e < DIR_SETUP) return;
    pos = e - DIR_SETUP;
    for (int k = 1; k <= n; k++) begin
      remain = n - k;
      if (pos < HIGH_CYC) begin
        pul_on = 1'b1;
        return;
      end
      pos -= HIGH_CYC;
      lw = low_width(k, n);
      if (pos < lw) return;
      pos -= lw;
    end
    remain = 0;
    if (pos == 0) begin
      done = 1'b1;
      return;
    end
    busy = 1'b0;
  endtask

  bit          m_active;
  int          m_cyc;
  int          m_start;
  int          m_n;
  logic [5:0]  m_sel;
  logic [5:0]  m_dir;
  logic [21:0] m_last;

  always @(posedge sysclk or posedge INIT) begin
    if (INIT) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_start  = 0;
      m_n      = 0;
      m_sel    = 6'd0;
      m_dir    = 6'd0;
      m_last   = 22'd0;
    end else begin
      if (m_active && (m_cyc - m_start) >= move_len(m_n)) m_active = 1'b0;
      m_cyc++;
      if (!m_active && $onehot(bus.MotorOut) && bus.PulseNum != 10'd0 &&
          {bus.MotorOut, bus.PulseNum, bus.DROut} != m_last) begin
        m_active = 1'b1;
        m_start  = m_cyc;
        m_n      = int'(bus.PulseNum);
        m_sel    = bus.MotorOut;
        m_dir    = (m_dir & ~bus.MotorOut) | (bus.DROut & bus.MotorOut);
        m_last   = {bus.MotorOut, bus.PulseNum, bus.DROut};
      end
    end
  end

  always @(negedge sysclk) begin : compare
    logic eb, ep, ed;
    int   er;
    if (!INIT) begin
      if (m_active) expect_at(m_cyc - m_start, m_n, eb, ep, ed, er);
      else begin
        eb = 1'b0; ep = 1'b0; ed = 1'b0; er = 0;
      end
      checkOutput("model_Busy", int'(bus.Busy), int'(eb));
      checkOutput("model_PUL", int'(bus.PUL), ep ? int'(m_sel) : 0);
      checkOutput("model_DIR", int'(bus.DIR), int'(m_dir));
      checkOutput("model_Done", int'(bus.Done), int'(ed));
      checkOutput("model_Remain", int'(bus.Remain), er);
    end
  end

  // Waveform monitor feeding the literal checks: pulse count, Done count, Busy length, LOW widths.
  int         rises;
  int         done_pulses;
  int         busy_samples;
  int         gaps[$];
  bit         gap_on;
  int         gap_cnt;
  logic [5:0] prev_pul;

  always @(negedge sysclk) begin
    if (INIT) begin
      prev_pul = 6'd0;
      gap_on   = 1'b0;
    end else begin
      if (bus.Busy) busy_samples++;
      if (bus.Done) done_pulses++;
      if (bus.PUL != 6'd0 && prev_pul == 6'd0) begin
        rises++;
        if (gap_on) gaps.push_back(gap_cnt);
        gap_on = 1'b0;
      end else if (bus.Done && gap_on) begin
        gaps.push_back(gap_cnt);
        gap_on = 1'b0;
      end else if (bus.PUL == 6'd0 && prev_pul != 6'd0) begin
        gap_on  = 1'b1;
        gap_cnt = 1;
      end else if (gap_on) begin
        gap_cnt++;
      end
      prev_pul = bus.PUL;
    end
  end

  task automatic next_sample();
    @(negedge sysclk);
    #1;
  endtask

  task automatic clear_monitor();
    rises        = 0;
    done_pulses  = 0;
    busy_samples = 0;
    gaps.delete();
  endtask

  task automatic applyStimulus(input logic [5:0] m, input logic [9:0] n, input logic [5:0] d);
    next_sample();
    bus.MotorOut = m;
    bus.PulseNum = n;
    bus.DROut    = d;
  endtask

  task automatic do_reset();
    bus.MotorOut = 6'd0;
    bus.PulseNum = 10'd0;
    bus.DROut    = 6'd0;
    @(negedge sysclk);
    #2 INIT = 1'b1;
    next_sample();
    next_sample();
    INIT = 1'b0;
    next_sample();
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int c;
    c = 0;
    do begin
      next_sample();
      c++;
    end while (bus.Busy && c < max_cyc);
    if (bus.Busy) timeout_fail(name);
  endtask

  task automatic wait_busy(input int max_cyc, input string name);
    int c;
    c = 0;
    do begin
      next_sample();
      c++;
    end while (!bus.Busy && c < max_cyc);
    if (!bus.Busy) timeout_fail(name);
  endtask

  initial begin
    int c;
    int exp_gap;

    $display("[TB] reset then idle");
    do_reset();
    checkOutput("reset_Busy", int'(bus.Busy), 0);
    checkOutput("reset_PUL", int'(bus.PUL), 0);
    checkOutput("reset_DIR", int'(bus.DIR), 0);
    checkOutput("reset_Done", int'(bus.Done), 0);
    checkOutput("reset_Remain", int'(bus.Remain), 0);
    repeat (5) next_sample();
    checkOutput("idle_Busy", int'(bus.Busy), 0);

    $display("[TB] basic move motor 2, 3 steps, reverse");
    clear_monitor();
    applyStimulus(6'b000100, 10'd3, 6'b000100);
    checkOutput("busy_before_accept", int'(bus.Busy), 0);
    next_sample();
    checkOutput("busy_one_cycle_later", int'(bus.Busy), 1);
    checkOutput("dir_latched", int'(bus.DIR), 6'b000100);
    checkOutput("remain_loaded", int'(bus.Remain), 3);
    wait_idle(2000, "basic_idle");
    checkOutput("basic_pulses", rises, 3);
    checkOutput("basic_done_count", done_pulses, 1);
    checkOutput("basic_busy_len", busy_samples, 311);
    checkOutput("basic_gap_count", gaps.size(), 3);
    for (int i = 0; i < gaps.size(); i++) checkOutput("basic_low_width", gaps[i], 50);

    $display("[TB] invalid and repeated commands");
    clear_monitor();
    applyStimulus(6'b000011, 10'd3, 6'b000000);
    repeat (5) next_sample();
    applyStimulus(6'b000100, 10'd0, 6'b000100);
    repeat (5) next_sample();
    applyStimulus(6'b000000, 10'd3, 6'b000000);
    repeat (5) next_sample();
    applyStimulus(6'b000100, 10'd3, 6'b000100);
    repeat (20) next_sample();
    checkOutput("ignored_pulses", rises, 0);
    checkOutput("ignored_busy", busy_samples, 0);

    $display("[TB] command change during a move");
    do_reset();
    clear_monitor();
    applyStimulus(6'b000100, 10'd3, 6'b000100);
    repeat (100) next_sample();
    applyStimulus(6'b000100, 10'd5, 6'b000100);
    wait_idle(2000, "midmove_first_idle");
    checkOutput("midmove_first_pulses", rises, 3);
    clear_monitor();
    wait_busy(10, "midmove_second_busy");
    wait_idle(3000, "midmove_second_idle");
    checkOutput("midmove_second_pulses", rises, 5);
    checkOutput("midmove_second_done", done_pulses, 1);
    checkOutput("midmove_second_busy_len", busy_samples, 511);

    $display("[TB] abort by INIT after pulse 2");
    do_reset();
    clear_monitor();
    applyStimulus(6'b000100, 10'd3, 6'b000100);
    c = 0;
    while (!(rises == 2 && bus.PUL == 6'd0) && c < 1000) begin
      next_sample();
      c++;
    end
    if (!(rises == 2 && bus.PUL == 6'd0)) timeout_fail("abort_wait");
    checkOutput("abort_remain_before", int'(bus.Remain), 1);
    checkOutput("abort_dir_before", int'(bus.DIR), 6'b000100);
    #2 INIT = 1'b1;
    #1;
    checkOutput("abort_PUL", int'(bus.PUL), 0);
    checkOutput("abort_Busy", int'(bus.Busy), 0);
    checkOutput("abort_Remain", int'(bus.Remain), 0);
    checkOutput("abort_DIR", int'(bus.DIR), 0);
    bus.MotorOut = 6'd0;
    bus.PulseNum = 10'd0;
    bus.DROut    = 6'd0;
    next_sample();
    INIT = 1'b0;
    next_sample();

    $display("[TB] 20-step move on motor 0");
    clear_monitor();
    applyStimulus(6'b000001, 10'd20, 6'b000000);
    wait_idle(9000, "long_idle");
    checkOutput("long_pulses", rises, 20);
    checkOutput("long_gap_count", gaps.size(), 20);
    for (int i = 0; i < gaps.size() && i < 20; i++) begin
`ifdef SOFTSTART_EN
      exp_gap = (i < 8 || i >= 12) ? 200 : 50;
`else
      exp_gap = 50;
`endif
      checkOutput("long_low_width", gaps[i], exp_gap);
    end

    repeat (3) next_sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
